// File: rtl/fetch_queue.sv
// Prefetch queue: owns the fetch PC, buffers one instruction word per cycle in a
// circular FIFO and hands {instruction, PC+4} to decode; a redirect flushes and restarts.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             Clk,
  input  logic             Reset,
  output logic [31:0]      ImemAddr,
  input  logic [31:0]      ImemData,
  input  logic             Redirect,
  input  logic [31:0]      RedirectPC,
  input  logic             DecodeReady,
  output logic             InstrValid,
  output logic [31:0]      InstrOut,
  output logic [31:0]      PCPlus4Out,
  output logic [PTR_W:0]   Count
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FULL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  state_t           stateReg;
  logic [31:0]      fetchPcReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W:0]   countReg;
  logic [PTR_W:0]   countNext;
  logic [63:0]      entryReg [DEPTH];
  logic [63:0]      headEntry;
  logic             push;
  logic             pop;

  assign headEntry  = entryReg[rdPtrReg];
  assign InstrValid = (countReg != '0);
  // Gating keeps stale or never-written storage off the decode bus.
  assign InstrOut   = InstrValid ? headEntry[63:32] : 32'h0;
  assign PCPlus4Out = InstrValid ? headEntry[31:0]  : 32'h0;
  assign ImemAddr   = fetchPcReg;
  assign Count      = countReg;

  assign pop  = InstrValid & DecodeReady & ~Redirect;
  assign push = ~Redirect & ((countReg != FULL_CNT) | pop);

  always_comb begin
    countNext = countReg;
    unique case ({push, pop})
      2'b10:   countNext = countReg + (PTR_W + 1)'(1);
      2'b01:   countNext = countReg - (PTR_W + 1)'(1);
      default: countNext = countReg;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg   <= FILL;
      fetchPcReg <= RESET_PC;
      rdPtrReg   <= '0;
      wrPtrReg   <= '0;
      countReg   <= '0;
    end else if (Redirect) begin
      stateReg   <= FLUSH;
      fetchPcReg <= RedirectPC & ~32'h3;
      rdPtrReg   <= '0;
      wrPtrReg   <= '0;
      countReg   <= '0;
    end else begin
      if (push) begin
        wrPtrReg   <= wrPtrReg + PTR_W'(1);
        fetchPcReg <= fetchPcReg + 32'd4;
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      countReg <= countNext;
      // State is derived from the next occupancy so it can never disagree with Count.
      if (countNext == '0) begin
        stateReg <= FILL;
      end else if (countNext == FULL_CNT) begin
        stateReg <= FULL;
      end else begin
        stateReg <= RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && push) begin
      entryReg[wrPtrReg] <= {ImemData, fetchPcReg + 32'd4};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus rebuilds an expected fetch stream on every
// reset/redirect; a negedge monitor pops it on each accepted head and checks invariants.
module tb_fetch_queue;

  logic        Clk;
  logic        Reset;
  logic [31:0] ImemAddr;
  logic [31:0] ImemData;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        DecodeReady;
  logic        InstrValid;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;
  logic [63:0] sbQ [$];

  fetch_queue #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .ImemAddr(ImemAddr), .ImemData(ImemData),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .DecodeReady(DecodeReady),
    .InstrValid(InstrValid), .InstrOut(InstrOut), .PCPlus4Out(PCPlus4Out), .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  // Garbage on the data bus whenever no push can legally happen.
  assign ImemData = Redirect ? 32'hDEADBEEF : imemWord(ImemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h at %0t", name, act, $time);
    end
  endtask

  task automatic sbRestart(input logic [31:0] base);
    logic [31:0] addr;
    sbQ.delete();
    for (int k = 0; k < 64; k++) begin
      addr = base + 32'(4 * k);
      sbQ.push_back({imemWord(addr), addr + 32'd4});
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each accepted head.
  always @(negedge Clk) begin
    int st;
    logic okSt;
    logic [63:0] exp;
    st = int'(dut.stateReg);
    if (Count == 3'd0)      okSt = (st == 0) || (st == 3);
    else if (Count == 3'd4) okSt = (st == 2);
    else                    okSt = (st == 1);
    total++;
    if (!okSt) begin
      bad++;
      $display("FAIL state_vs_count: state=%0d count=%0d at %0t", st, Count, $time);
    end
    total++;
    if (InstrValid !== (Count != 3'd0)) begin
      bad++;
      $display("FAIL valid_vs_count: valid=%b count=%0d at %0t", InstrValid, Count, $time);
    end
    if (!InstrValid) begin
      total++;
      if (InstrOut !== 32'h0 || PCPlus4Out !== 32'h0) begin
        bad++;
        $display("FAIL idle_zero: instr=%h pc4=%h expected 0 at %0t", InstrOut, PCPlus4Out, $time);
      end
    end
    if (Reset && InstrValid && DecodeReady && !Redirect) begin
      total++;
      if (sbQ.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got instr=%h pc4=%h with nothing expected at %0t",
                 InstrOut, PCPlus4Out, $time);
      end else begin
        exp = sbQ.pop_front();
        if (InstrOut !== exp[63:32] || PCPlus4Out !== exp[31:0]) begin
          bad++;
          $display("FAIL sb_pop: got %h/%h expected %h/%h at %0t",
                   InstrOut, PCPlus4Out, exp[63:32], exp[31:0], $time);
        end else begin
          $display("pop  %h/%h at %0t", InstrOut, PCPlus4Out, $time);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0; DecodeReady = 1'b0;
    sbRestart(32'h0);
    #2;
    chk("rst_valid", 32'(InstrValid), 32'h0);
    chk("rst_instr", InstrOut, 32'h0);
    chk("rst_pc4", PCPlus4Out, 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    chk("rst_addr", ImemAddr, 32'h0);

    // T1: stream after reset release
    tick();
    DecodeReady = 1'b1;
    Reset = 1'b1;
    chk("t1_valid_before_edge", 32'(InstrValid), 32'h0);
    tick();
    chk("t1_valid", 32'(InstrValid), 32'h1);
    chk("t1_instr", InstrOut, 32'h1000);
    chk("t1_pc4", PCPlus4Out, 32'h4);
    chk("t1_count", 32'(Count), 32'h1);
    repeat (8) tick();
    chk("t1_addr", ImemAddr, 32'h24);
    chk("t1_count_steady", 32'(Count), 32'h1);

    // T2: backpressure from a fresh reset
    Reset = 1'b0;
    DecodeReady = 1'b0;
    #1;
    chk("t2_async_count", 32'(Count), 32'h0);
    chk("t2_async_addr", ImemAddr, 32'h0);
    sbRestart(32'h0);
    tick();
    Reset = 1'b1;
    repeat (10) tick();
    chk("t2_count_full", 32'(Count), 32'h4);
    chk("t2_addr_hold", ImemAddr, 32'h10);
    chk("t2_head", InstrOut, 32'h1000);

    // T3: full + pop keeps Count at DEPTH while fetch advances
    DecodeReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_count", 32'(Count), 32'h4);
      chk("t3_addr", ImemAddr, 32'h10 + 32'(4 * i));
    end

    // T4: build Count=3, then redirect to 0x43
    Redirect = 1'b1; RedirectPC = 32'h100; DecodeReady = 1'b0;
    sbRestart(32'h100);
    tick();
    chk("t4_flush_count", 32'(Count), 32'h0);
    chk("t4_flush_addr", ImemAddr, 32'h100);
    Redirect = 1'b0;
    repeat (3) tick();
    chk("t4_count3", 32'(Count), 32'h3);
    chk("t4_addr3", ImemAddr, 32'h10C);
    Redirect = 1'b1; RedirectPC = 32'h43; DecodeReady = 1'b1;
    sbRestart(32'h40);
    tick();
    chk("t4_count", 32'(Count), 32'h0);
    chk("t4_addr", ImemAddr, 32'h40);
    chk("t4_valid", 32'(InstrValid), 32'h0);
    chk("t4_state_flush", 32'(int'(dut.stateReg)), 32'h3);
    Redirect = 1'b0;
    tick();
    chk("t4_tgt_valid", 32'(InstrValid), 32'h1);
    chk("t4_tgt_instr", InstrOut, 32'h1010);
    chk("t4_tgt_pc4", PCPlus4Out, 32'h44);

    // T5: async reset between edges while FULL
    DecodeReady = 1'b0;
    repeat (3) tick();
    chk("t5_full", 32'(Count), 32'h4);
    #2;
    Reset = 1'b0;
    sbRestart(32'h0);
    #1;
    chk("t5_valid", 32'(InstrValid), 32'h0);
    chk("t5_instr", InstrOut, 32'h0);
    chk("t5_pc4", PCPlus4Out, 32'h0);
    chk("t5_count", 32'(Count), 32'h0);
    chk("t5_addr", ImemAddr, 32'h0);
    tick();
    Reset = 1'b1; DecodeReady = 1'b1;
    tick();
    chk("t5_restart_instr", InstrOut, 32'h1000);

    // T6: 32-bit PC wrap and pointer wrap
    Redirect = 1'b1; RedirectPC = 32'hFFFFFFF8;
    sbRestart(32'hFFFFFFF8);
    tick();
    chk("t6_addr", ImemAddr, 32'hFFFFFFF8);
    Redirect = 1'b0;
    tick();
    chk("t6_pc4_a", PCPlus4Out, 32'hFFFFFFFC);
    chk("t6_instr_a", InstrOut, 32'h40000FFE);
    tick();
    chk("t6_pc4_b", PCPlus4Out, 32'h0);
    tick();
    chk("t6_pc4_c", PCPlus4Out, 32'h4);
    DecodeReady = 1'b0;
    repeat (6) tick();
    chk("t6_full", 32'(Count), 32'h4);
    DecodeReady = 1'b1;
    repeat (8) tick();
    chk("t6_count_end", 32'(Count), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
